// File: rtl/hist_pkg.sv
// Shared definitions for the histogram accumulator: default widths, FSM
// encoding and the zero-delay bin shared with plot_distributer.
package hist_pkg;

  localparam int ADDR_W_DEF   = 7;
  localparam int CNT_W_DEF    = 16;
  localparam int DROP_W_DEF   = 8;

  // Bin that plot_distributer maps a zero time difference onto.
  localparam int ADDRESS_ZERO = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_INC_RD  = 3'd2,
    ST_INC_WR  = 3'd3,
    ST_HRD_RD  = 3'd4,
    ST_HRD_OUT = 3'd5
  } hist_state_e;

endpackage

// File: rtl/hist_bram.sv
// Single-port RAM with synchronous read (read-first), written so that
// synthesis maps it onto a block RAM primitive.
module hist_bram
  import hist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: storage has no reset; a reset branch would prevent block-RAM
  // inference. The owner clears the contents with an explicit sweep instead.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/histogram_accumulator.sv
// 128-bin time-correlation histogram: read-modify-write increment per
// Memory_add rising edge, host single-bin readout and full clear.
module histogram_accumulator
  import hist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Memory_add,
  input  logic              clear_req,
  input  logic              host_rd_req,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [CNT_W-1:0]  host_rd_data,
  output logic              host_rd_valid,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count,
  output logic [31:0]       total_count
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  hist_state_e state_q, state_d;

  logic              mem_add_q;
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [ADDR_W-1:0] inc_addr_q;
  logic              hslot_valid_q;
  logic [ADDR_W-1:0] hslot_addr_q;
  logic [ADDR_W-1:0] hrd_addr_q;
  logic              clr_pend_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic [CNT_W-1:0]  host_rd_data_q;
  logic [DROP_W-1:0] drop_q;
  logic [31:0]       total_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [CNT_W-1:0]  ram_wdata;
  logic [CNT_W-1:0]  ram_rdata;

  logic              req_edge;
  logic              req_drop;
  logic              req_accept;
  logic              clear_go;
  logic              host_go;
  logic [ADDR_W-1:0] host_sel_addr;
  logic              enter_clear;

  hist_bram #(
    .ADDR_W (ADDR_W),
    .DATA_W (CNT_W)
  ) u_bram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign req_edge = Memory_add & ~mem_add_q;

  // clr_pend_q powers up set, which makes the post-reset sweep mandatory and
  // also remembers a clear_req that arrives while an operation is in flight.
  assign clear_go = clear_req | clr_pend_q;

  // A request is lost while a clear is running or about to start, or when
  // the pending slot is full and not being emptied this very cycle.
  assign req_drop = req_edge &
                    ((state_q == ST_CLEAR) | clear_req |
                     ((state_q == ST_IDLE) & clr_pend_q) |
                     (pend_valid_q & (state_q != ST_INC_RD)));
  assign req_accept = req_edge & ~req_drop;

  assign host_go       = host_rd_req | hslot_valid_q;
  assign host_sel_addr = host_rd_req ? host_rd_addr : hslot_addr_q;
  assign enter_clear   = (state_d == ST_CLEAR) & (state_q != ST_CLEAR);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_addr  = pend_addr_q;
    ram_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_go) begin
          state_d = ST_CLEAR;
        end else if (pend_valid_q) begin
          state_d = ST_INC_RD;
        end else if (host_go) begin
          state_d = ST_HRD_RD;
        end
      end
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_idx_q;
        if (!clear_req && (&clr_idx_q)) begin
          state_d = ST_IDLE;
        end
      end
      ST_INC_RD: begin
        ram_addr = pend_addr_q;
        state_d  = ST_INC_WR;
      end
      ST_INC_WR: begin
        ram_we    = 1'b1;
        ram_addr  = inc_addr_q;
        ram_wdata = (ram_rdata == CNT_MAX) ? CNT_MAX : ram_rdata + CNT_W'(1);
        state_d   = ST_IDLE;
      end
      ST_HRD_RD: begin
        ram_addr = hrd_addr_q;
        state_d  = ST_HRD_OUT;
      end
      ST_HRD_OUT: begin
        ram_addr = hrd_addr_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_add_q      <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_addr_q    <= '0;
      inc_addr_q     <= '0;
      hslot_valid_q  <= 1'b0;
      hslot_addr_q   <= '0;
      hrd_addr_q     <= '0;
      clr_pend_q     <= 1'b1;
      clr_idx_q      <= '0;
      host_rd_data_q <= '0;
      drop_q         <= '0;
      total_q        <= '0;
    end else begin
      mem_add_q <= Memory_add;

      if (req_accept) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= Addr;
      end else if (state_q == ST_INC_RD) begin
        pend_valid_q <= 1'b0;
      end

      if (state_q == ST_INC_RD) begin
        inc_addr_q <= pend_addr_q;
      end

      if (req_drop && (drop_q != DROP_MAX)) begin
        drop_q <= drop_q + DROP_W'(1);
      end

      // A host request taken straight out of IDLE bypasses the slot.
      if ((state_q == ST_IDLE) && (state_d == ST_HRD_RD)) begin
        hslot_valid_q <= 1'b0;
        hrd_addr_q    <= host_sel_addr;
      end else if (host_rd_req) begin
        hslot_valid_q <= 1'b1;
        hslot_addr_q  <= host_rd_addr;
      end

      if (state_d == ST_CLEAR) begin
        clr_pend_q <= 1'b0;
      end else if (clear_req) begin
        clr_pend_q <= 1'b1;
      end

      clr_idx_q <= ((state_q == ST_CLEAR) && !clear_req) ? clr_idx_q + ADDR_W'(1) : '0;

      if (enter_clear) begin
        total_q <= '0;
      end else if (state_q == ST_INC_WR) begin
        total_q <= total_q + 32'd1;
      end

      if (state_q == ST_HRD_OUT) begin
        host_rd_data_q <= ram_rdata;
      end
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign host_rd_valid = (state_q == ST_HRD_OUT);
  assign host_rd_data  = host_rd_valid ? ram_rdata : host_rd_data_q;
  assign drop_count    = drop_q;
  assign total_count   = total_q;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Directed bench for histogram_accumulator against a bin-array model.
module tb_histogram_accumulator;
  import hist_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  Addr = '0;
  logic        Memory_add = 1'b0;
  logic        clear_req = 1'b0;
  logic        host_rd_req = 1'b0;
  logic [6:0]  host_rd_addr = '0;
  logic [15:0] host_rd_data;
  logic        host_rd_valid;
  logic        busy;
  logic [7:0]  drop_count;
  logic [31:0] total_count;

  histogram_accumulator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Addr          (Addr),
    .Memory_add    (Memory_add),
    .clear_req     (clear_req),
    .host_rd_req   (host_rd_req),
    .host_rd_addr  (host_rd_addr),
    .host_rd_data  (host_rd_data),
    .host_rd_valid (host_rd_valid),
    .busy          (busy),
    .drop_count    (drop_count),
    .total_count   (total_count)
  );

  always #5 clk = ~clk;

  int unsigned model_bins [128];
  int unsigned m_total = 0;
  int unsigned m_drop = 0;
  int unsigned last_rd = 0;
  int          rd_q [$];
  bit          settled = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_inc(input int a);
    if (model_bins[a] < 32'd65535) model_bins[a]++;
    m_total++;
  endtask

  task automatic model_drop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_clear();
    foreach (model_bins[i]) model_bins[i] = 0;
    m_total = 0;
  endtask

  // 6-cycle high level followed by 4 low cycles (10-cycle request spacing).
  task automatic pulse(input int a);
    Addr = 7'(a);
    Memory_add = 1'b1;
    repeat (6) tick();
    Memory_add = 1'b0;
    repeat (4) tick();
  endtask

  task automatic rd(input int a, input bit chk_lat);
    host_rd_addr = 7'(a);
    host_rd_req = 1'b1;
    rd_q.push_back(a);
    tick();
    host_rd_req = 1'b0;
    if (chk_lat) begin
      check("rd_valid_c1", {31'd0, host_rd_valid}, 32'd0);
      tick();
      check("rd_valid_c2", {31'd0, host_rd_valid}, 32'd1);
      tick();
      check("rd_valid_c3", {31'd0, host_rd_valid}, 32'd0);
    end else begin
      repeat (2) tick();
    end
    tick();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  // Compare process: read data against the model, and the counters and the
  // held read data on every quiet idle cycle.
  always @(negedge clk) begin : compare
    int a;
    if (rst_n) begin
      if (host_rd_valid) begin
        if (rd_q.size() == 0) begin
          check("rd_valid_unexpected", {31'd0, host_rd_valid}, 32'd0);
        end else begin
          a = rd_q.pop_front();
          check($sformatf("rd_data[%0d]", a), {16'd0, host_rd_data}, model_bins[a]);
          last_rd = model_bins[a];
        end
      end else if (settled && !busy) begin
        check("total_count", total_count, m_total);
        check("drop_count", {24'd0, drop_count}, m_drop);
        check("rd_data_hold", {16'd0, host_rd_data}, last_rd);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int n;
    model_clear();

    // Reset state.
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, host_rd_valid}, 32'd0);
    check("rst_data", {16'd0, host_rd_data}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);
    check("rst_total", total_count, 32'd0);
    rst_n = 1'b1;

    // Auto-clear: busy rises on the first edge and stays high for 128 cycles.
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    check("autoclear_start", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check("autoclear_len", n, 32'd128);
    settled = 1'b1;
    repeat (2) tick();

    rd(0, 1'b1);
    check("lit_bin0", {16'd0, host_rd_data}, 32'd0);
    rd(ADDRESS_ZERO, 1'b1);
    rd(127, 1'b1);
    check("lit_bin127", {16'd0, host_rd_data}, 32'd0);

    // Five requests to the zero-delay bin.
    settled = 1'b0;
    for (int i = 0; i < 5; i++) begin
      model_inc(ADDRESS_ZERO);
      pulse(ADDRESS_ZERO);
    end
    settled = 1'b1;
    rd(ADDRESS_ZERO, 1'b1);
    check("lit_bin64", {16'd0, host_rd_data}, 32'd5);
    check("lit_total5", total_count, 32'd5);
    check("lit_drop0", {24'd0, drop_count}, 32'd0);

    // Neighbouring bins, one hit twice.
    settled = 1'b0;
    model_inc(61); pulse(61);
    model_inc(67); pulse(67);
    model_inc(61); pulse(61);
    settled = 1'b1;
    rd(61, 1'b0);
    check("lit_bin61", {16'd0, host_rd_data}, 32'd2);
    rd(67, 1'b0);
    check("lit_bin67", {16'd0, host_rd_data}, 32'd1);
    rd(ADDRESS_ZERO, 1'b0);
    check("lit_bin64_again", {16'd0, host_rd_data}, 32'd5);

    // Saturation: bin 10 preloaded one below full scale.
    settled = 1'b0;
    dut.u_bram.mem[10] = 16'hFFFE;
    model_bins[10] = 32'hFFFE;
    for (int i = 0; i < 3; i++) begin
      model_inc(10);
      pulse(10);
    end
    settled = 1'b1;
    rd(10, 1'b0);
    check("lit_bin10_sat", {16'd0, host_rd_data}, 32'h0000FFFF);
    check("lit_total11", total_count, 32'd11);

    // Clear with a request arriving five cycles into the sweep.
    settled = 1'b0;
    model_inc(20);
    pulse(20);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    model_clear();
    repeat (4) tick();
    model_drop();
    pulse(20);
    wait_idle("clear_done");
    settled = 1'b1;
    tick();
    check("lit_drop1", {24'd0, drop_count}, 32'd1);
    check("lit_total0", total_count, 32'd0);
    rd(0, 1'b0);
    rd(10, 1'b0);
    rd(20, 1'b0);
    check("lit_bin20_cleared", {16'd0, host_rd_data}, 32'd0);
    rd(61, 1'b0);
    rd(ADDRESS_ZERO, 1'b0);
    rd(67, 1'b0);
    rd(127, 1'b0);

    // Edges two cycles apart: accepted, accepted into refilled slot, dropped.
    // A host read issued in between is served after both increments.
    settled = 1'b0;
    model_inc(30);
    model_inc(31);
    model_drop();
    Addr = 7'd30; Memory_add = 1'b1;
    tick();
    Memory_add = 1'b0;
    host_rd_addr = 7'd31; host_rd_req = 1'b1;
    rd_q.push_back(31);
    tick();
    host_rd_req = 1'b0;
    Addr = 7'd31; Memory_add = 1'b1;
    tick();
    Memory_add = 1'b0;
    tick();
    Addr = 7'd32; Memory_add = 1'b1;
    tick();
    Memory_add = 1'b0;
    n = 0;
    while (rd_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("midseq_read_served", rd_q.size(), 32'd0);
    check("lit_bin31_midseq", {16'd0, host_rd_data}, 32'd1);
    wait_idle("burst_done");
    repeat (2) tick();
    settled = 1'b1;
    rd(30, 1'b0);
    check("lit_bin30", {16'd0, host_rd_data}, 32'd1);
    rd(32, 1'b0);
    check("lit_bin32", {16'd0, host_rd_data}, 32'd0);
    check("lit_total2", total_count, 32'd2);
    check("lit_drop2", {24'd0, drop_count}, 32'd2);

    repeat (5) tick();
    check("rd_queue_empty", rd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
